cryptoveril_sched: RTL and testbench
====================================

# cryptoveril_sched

Single-clock job scheduler that shares one cryptoveril encryption core between two requesters. Arbitrates round-robin between two valid/ready request ports and latches the winning word and key. Drives the core's ld/start sequencing, waits for completion or timeout, and returns the result tagged with the requester ID on a valid/ready response port. Sits between the bus-side clients and the core's input_data/key_bits/ld/start pins.

## Interface
- TIMEOUT_CYCLES, 64: max RUN cycles to wait for core_done before flagging an error (≥2)
- CNT_W, 7: width of the RUN cycle counter; must hold TIMEOUT_CYCLES-1
- clk1  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  requester has a job
- req0_data / req1_data  in  16  plaintext word
- req0_key / req1_key  in  5  key bits
- req0_ready / req1_ready  out  1  job accepted this cycle when valid&ready
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  16  core result (0 on error)
- rsp_id  out  1  requester that owns the result
- rsp_err  out  1  timeout occurred
- core_data  out  16  to core input_data
- core_key  out  5  to core key_bits
- core_ld  out  1  one-cycle load pulse
- core_start  out  1  held high while core runs
- core_done  in  1  core result valid (single cycle or level)
- core_result  in  16  core output_data
- busy  out  1  state != IDLE
- job_cnt  out  8  completed responses (incl. errors), wraps 255→0

## Operation
- FSM states: IDLE, LOAD, RUN, RESP.
- IDLE: grant = requester with valid; both valid → the one not equal to last_grant. reqN_ready = (state==IDLE) & grant==N, combinational; other ready 0. On handshake latch data, key, id; → LOAD. No valid → stay.
- LOAD: core_ld=1 exactly this cycle; core_data/core_key driven from latch (held stable LOAD through RESP); counter cleared; → RUN.
- RUN: core_start=1; counter +1 per cycle. core_done=1 → capture core_result, rsp_err=0, → RESP. Else counter == TIMEOUT_CYCLES-1 → rsp_data=0, rsp_err=1, → RESP. done and timeout same cycle: done wins, err=0.
- RESP: core_start=0; rsp_valid=1, rsp_data/id/err stable until rsp_ready. On rsp_valid&rsp_ready: last_grant←rsp_id, job_cnt+1, → IDLE.
- core_done outside RUN ignored.
- Requester dropping valid before handshake: no transfer, no state change.
- Reset (any state, incl. mid-RUN): state IDLE, last_grant=1 (req0 first), counter 0, job_cnt 0, latched data/key/id 0; all outputs 0. In-flight job discarded, no response.

## Timing
- Reset values: every output 0.
- Handshake at cycle T → core_ld=1 at T+1 → core_start=1 from T+2.
- core_done sampled at cycle D (≥T+2) → rsp_valid=1 at D+1; minimum accept-to-response 3 cycles.
- Timeout: no done → rsp_valid at T+2+TIMEOUT_CYCLES with rsp_err=1.
- Response accepted at cycle R → IDLE at R+1; next reqN_ready earliest R+1 (one bubble cycle per job).
- rsp_ready held high throughout: response consumed first cycle of RESP.
- Only one job in flight; no request queuing.

## Structure
- Package cryptoveril_sched_pkg: state enum (IDLE, LOAD, RUN, RESP), DATA_W=16, KEY_W=5, default TIMEOUT_CYCLES.
- Sub-module rr_arbiter2: 2-way round-robin grant from two valids plus last_grant; purely combinational, reusable for future core sharing.
- Top holds FSM, latches, RUN counter, job_cnt.

## Test plan
- Single job: req0_data=16'h0001, key=5'b00110, core_done at 4th RUN cycle with core_result=16'hA5C3 → core_ld one cycle at T+1, rsp_valid at D+1, rsp_data=16'hA5C3, rsp_id=0, rsp_err=0, job_cnt=1.
- Contention: both valid after reset → req0 served first, then req1 (rsp_id 0 then 1); repeated double contention alternates 0,1,0,1.
- Timeout: TIMEOUT_CYCLES=8, core_done never → rsp_valid at T+10, rsp_err=1, rsp_data=16'h0000; next job completes normally.
- Backpressure/simultaneous: rsp_ready low 5 cycles → rsp_* stable, reqN_ready 0; done on exactly timeout cycle → rsp_err=0.
- Reset mid-RUN: assert rst 1 cycle during RUN → all outputs 0 next cycle, no response; subsequent req1 job served normally.
- Wrap: 256 completed jobs → job_cnt returns to 0.

Source files
------------

// File: rtl/cryptoveril_sched_pkg.sv
// rtl/cryptoveril_sched_pkg.sv - shared widths, defaults and FSM states for the crypto core scheduler
package cryptoveril_sched_pkg;
  localparam int DATA_W             = 16;
  localparam int KEY_W              = 5;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;
endpackage

// File: rtl/cryptoveril_sched_if.sv
// rtl/cryptoveril_sched_if.sv - request, response and core-side signal bundle of the scheduler
interface cryptoveril_sched_if;
  import cryptoveril_sched_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic [KEY_W-1:0]  req0_key;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic [KEY_W-1:0]  req1_key;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_id;
  logic              rsp_err;

  logic [DATA_W-1:0] core_data;
  logic [KEY_W-1:0]  core_key;
  logic              core_ld;
  logic              core_start;
  logic              core_done;
  logic [DATA_W-1:0] core_result;

  modport slave (
    input  req0_valid, req0_data, req0_key,
    input  req1_valid, req1_data, req1_key,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id, rsp_err,
    input  rsp_ready,
    output core_data, core_key, core_ld, core_start,
    input  core_done, core_result
  );

  modport master (
    output req0_valid, req0_data, req0_key,
    output req1_valid, req1_data, req1_key,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id, rsp_err,
    output rsp_ready,
    input  core_data, core_key, core_ld, core_start,
    output core_done, core_result
  );
endinterface

// File: rtl/cryptoveril_sched_rr_arbiter2.sv
// rtl/cryptoveril_sched_rr_arbiter2.sv - combinational two-way round-robin grant
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);
  always_comb begin
    grant_valid = |valid;
    grant_id    = 1'b0;
    // Under contention the requester that was not served last goes next.
    if (valid == 2'b11) grant_id = ~last_grant;
    else if (valid[1])  grant_id = 1'b1;
  end
endmodule

// File: rtl/cryptoveril_sched.sv
// rtl/cryptoveril_sched.sv - shares one cryptoveril core between two requesters, one job in flight
module cryptoveril_sched
  import cryptoveril_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = 7
) (
  input  logic                clk1,
  input  logic                rst,
  cryptoveril_sched_if.slave  bus,
  output logic                busy,
  output logic [7:0]          job_cnt
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_nx;
  logic              last_grant;
  logic [DATA_W-1:0] data_q;
  logic [KEY_W-1:0]  key_q;
  logic              id_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              err_q;
  logic [CNT_W-1:0]  run_cnt;
  logic              grant_valid, grant_id;
  logic              req_hs, rsp_hs, timeout;

  rr_arbiter2 u_arb (
    .valid       ({bus.req1_valid, bus.req0_valid}),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Ready is masked during reset so nothing is accepted on the reset edge.
  assign req_hs         = (state == IDLE) && grant_valid && !rst;
  assign bus.req0_ready = req_hs && !grant_id;
  assign bus.req1_ready = req_hs && grant_id;
  assign rsp_hs         = (state == RESP) && bus.rsp_ready;
  assign timeout        = (run_cnt == CNT_LAST);

  assign bus.core_data = data_q;
  assign bus.core_key  = key_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_err   = err_q;

  always_ff @(posedge clk1) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    bus.core_ld    = 1'b0;
    bus.core_start = 1'b0;
    bus.rsp_valid  = 1'b0;
    busy           = (state != IDLE);
    unique case (state)
      IDLE: if (req_hs) state_nx = LOAD;
      LOAD: begin
        bus.core_ld = 1'b1;
        state_nx    = RUN;
      end
      RUN: begin
        bus.core_start = 1'b1;
        if (bus.core_done || timeout) state_nx = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (rsp_hs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      last_grant <= 1'b1;
      data_q     <= '0;
      key_q      <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
      run_cnt    <= '0;
      job_cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: if (req_hs) begin
          id_q   <= grant_id;
          data_q <= grant_id ? bus.req1_data : bus.req0_data;
          key_q  <= grant_id ? bus.req1_key  : bus.req0_key;
        end
        LOAD: run_cnt <= '0;
        RUN: begin
          run_cnt <= run_cnt + 1'b1;
          // A done arriving on the last allowed cycle still counts as success.
          if (bus.core_done) begin
            rsp_data_q <= bus.core_result;
            err_q      <= 1'b0;
          end else if (timeout) begin
            rsp_data_q <= '0;
            err_q      <= 1'b1;
          end
        end
        RESP: if (rsp_hs) begin
          last_grant <= id_q;
          job_cnt    <= job_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cryptoveril_sched.sv
// tb/tb_cryptoveril_sched.sv - scoreboard bench for the crypto core scheduler
module tb_cryptoveril_sched;
  localparam int TO = 8;

  logic       clk1 = 1'b0;
  logic       rst  = 1'b1;
  logic       busy;
  logic [7:0] job_cnt;

  cryptoveril_sched_if bus();

  cryptoveril_sched #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
    .clk1    (clk1),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .job_cnt (job_cnt)
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          id_log[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          exp_cnt = 0;
  int          force_idx = -1;
  logic        force_res_en = 1'b0;
  logic [15:0] force_res = 16'h0;
  int          rdy_mode = 0;

  always @(posedge clk1) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference core: arbitrary keyed mix; key value picks the RUN cycle of done, >= TO never finishes.
  function automatic logic [15:0] core_fn(input logic [15:0] d, input logic [4:0] k);
    return (d ^ {k, k, k, 1'b0}) + 16'h1357;
  endfunction

  function automatic int target(input logic [4:0] k);
    if (force_idx >= 0) return force_idx;
    return (int'(k) < TO) ? int'(k) : -1;
  endfunction

  int          cm_t = -1;
  int          cm_idx = 0;
  logic [15:0] cm_d;
  logic [4:0]  cm_k;
  always @(negedge clk1) begin
    bus.core_done   = 1'b0;
    bus.core_result = 16'($urandom);
    if (bus.core_ld) begin
      cm_d   = bus.core_data;
      cm_k   = bus.core_key;
      cm_t   = target(cm_k);
      cm_idx = 0;
    end else if (bus.core_start) begin
      if (cm_idx == cm_t) begin
        bus.core_done   = 1'b1;
        bus.core_result = force_res_en ? force_res : core_fn(cm_d, cm_k);
      end
      cm_idx++;
    end else begin
      bus.core_done = ($urandom_range(0, 3) == 0);
    end
  end

  always @(negedge clk1)
    bus.rsp_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;

  int   first_c = 0;
  logic prev_v = 1'b0;
  always @(negedge clk1) begin
    exp_t e;
    logic ok;
    #2;
    if (!rst) begin
      if (bus.rsp_valid && !prev_v) first_c = cyc;
      if (bus.rsp_valid && bus.rsp_ready) begin
        ok = 1'b0;
        if (!bus.rsp_id && q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
        else if (bus.rsp_id && q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
        chk("rsp_expected", 32'(ok), 32'd1);
        if (ok) begin
          chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
          chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          chk("rsp_cycle", 32'(first_c), 32'(e.cyc));
          chk("job_cnt", 32'(job_cnt), 32'(exp_cnt & 255));
        end
        exp_cnt++;
        id_log.push_back(int'(bus.rsp_id));
      end
    end
    prev_v = bus.rsp_valid;
  end

  task automatic do_req(input int id, input logic [15:0] d, input logic [4:0] k);
    int   n;
    int   t;
    logic hs;
    exp_t e;
    @(negedge clk1);
    if (id == 0) begin bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_key = k; end
    else         begin bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_key = k; end
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 400) begin
      #1;
      hs = (id == 0) ? bus.req0_ready : bus.req1_ready;
      if (hs) begin
        t      = target(k);
        e.err  = (t < 0) || (t > TO - 1);
        e.data = e.err ? 16'h0 : (force_res_en ? force_res : core_fn(d, k));
        e.cyc  = e.err ? cyc + 2 + TO : cyc + 3 + t;
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
      end
      @(negedge clk1);
      n++;
    end
    if (id == 0) bus.req0_valid = 1'b0;
    else         bus.req1_valid = 1'b0;
    chk("req_accept", 32'(hs), 32'd1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q0.size() + q1.size() != 0 || busy) && n < 2000) begin
      @(negedge clk1);
      n++;
    end
    chk(name, 32'(n < 2000), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk1);
    rst = 1'b1;
    @(negedge clk1);
    #1;
    q0.delete();
    q1.delete();
    id_log.delete();
    exp_cnt = 0;
    chk("rst_ctrl", 32'({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id,
                         bus.rsp_err, bus.core_ld, bus.core_start, busy}), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_core_bus", 32'({bus.core_data, bus.core_key}), 32'd0);
    chk("rst_job_cnt", 32'(job_cnt), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet_bad;
    int n;
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_key = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_key = '0;
    do_reset();

    // Single job with a fixed result and done on the 4th RUN cycle.
    force_idx = 3; force_res_en = 1'b1; force_res = 16'hA5C3;
    do_req(0, 16'h0001, 5'b00110);
    #1;
    chk("ld_at_t1", 32'(bus.core_ld), 32'd1);
    chk("start_at_t1", 32'(bus.core_start), 32'd0);
    @(negedge clk1); #1;
    chk("ld_at_t2", 32'(bus.core_ld), 32'd0);
    chk("start_at_t2", 32'(bus.core_start), 32'd1);
    drain("single_drain");
    chk("single_job_cnt", 32'(job_cnt), 32'd1);
    force_idx = -1; force_res_en = 1'b0;

    // Double contention from reset alternates 0,1,0,1,...
    do_reset();
    repeat (3) begin
      fork
        do_req(0, 16'($urandom), 5'($urandom_range(0, 7)));
        do_req(1, 16'($urandom), 5'($urandom_range(0, 7)));
      join
      drain("contend_drain");
    end
    chk("contend_count", 32'(id_log.size()), 32'd6);
    for (int i = 0; i < id_log.size(); i++) chk("contend_order", 32'(id_log[i]), 32'(i % 2));

    // Timeout, recovery, and done on the final allowed RUN cycle.
    do_req(0, 16'h1234, 5'd20);
    drain("timeout_drain");
    do_req(1, 16'hBEEF, 5'd2);
    drain("recover_drain");
    do_req(1, 16'h0F0F, 5'd7);
    drain("edge_drain");

    // Response backpressure: outputs hold, no request accepted.
    rdy_mode = 2;
    do_req(0, 16'h5A5A, 5'd1);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin @(negedge clk1); n++; end
    chk("bp_rsp_seen", 32'(n < 50), 32'd1);
    repeat (5) begin
      #1;
      chk("bp_data", 32'(bus.rsp_data), 32'(core_fn(16'h5A5A, 5'd1)));
      chk("bp_id_err", 32'({bus.rsp_id, bus.rsp_err}), 32'd0);
      bus.req1_valid = 1'b1;
      #1;
      chk("bp_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      bus.req1_valid = 1'b0;
      @(negedge clk1);
    end
    rdy_mode = 0;
    drain("bp_drain");

    // Reset during RUN discards the job.
    do_req(0, 16'hCAFE, 5'd25);
    @(negedge clk1); #1;
    chk("mid_run_start", 32'(bus.core_start), 32'd1);
    do_reset();
    quiet_bad = 0;
    repeat (15) begin
      @(negedge clk1); #1;
      if (bus.rsp_valid) quiet_bad++;
    end
    chk("no_rsp_after_rst", 32'(quiet_bad), 32'd0);
    do_req(1, 16'h7777, 5'd3);
    drain("after_rst_drain");
    chk("after_rst_job_cnt", 32'(job_cnt), 32'd1);

    // Randomized traffic, 256 jobs total so job_cnt wraps to 0.
    do_reset();
    rdy_mode = 1;
    fork
      for (int i = 0; i < 128; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk1);
        do_req(0, 16'($urandom), 5'($urandom_range(0, 31)));
      end
      for (int j = 0; j < 128; j++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk1);
        do_req(1, 16'($urandom), 5'($urandom_range(0, 31)));
      end
    join
    rdy_mode = 0;
    drain("random_drain");
    #1;
    chk("wrap_responses", 32'(exp_cnt), 32'd256);
    chk("wrap_job_cnt", 32'(job_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
